// File: rtl/wb_pkg.sv
// Shared constants for the ALU writeback stage: result-source selects,
// load funct3 codes and the output-queue FSM encoding.
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;
    localparam logic [1:0] WB_SEL_IMM = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Load data alignment and extension: picks the addressed byte/halfword out of
// an aligned memory word and sign- or zero-extends it to XLEN.
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_low,
    output logic [XLEN-1:0] ext_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (addr_low)
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
    end

    // Halfword loads are assumed aligned; the low offset bit is ignored.
    assign ld_half = addr_low[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ext_data = mem_rdata;
        case (funct3)
            F3_LB:   ext_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, ld_byte};
            F3_LH:   ext_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, ld_half};
            F3_LW:   ext_data = mem_rdata;
            default: ext_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Writeback stage: selects the register write-back value and presents one
// register-file write per instruction behind a 2-entry skid buffer.
// Optional macro WB_RETIRE_COUNT_EN adds the retire_count output.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  ST_EMPTY | output register empty, stage accepts
//  ST_ONE   | output register valid, skid empty, stage accepts
//  ST_TWO   | output register and skid valid, in_ready low
module alu_writeback_stage
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        wb_sel,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   immediate,
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_low,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              rd_wen,
    input  logic              rf_ready,
    output logic              out_valid,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [XLEN-1:0]   retire_count
`endif
);

    wb_state_e         state_q, state_d;
    logic              in_ready_q, in_ready_d;

    logic [REG_AW-1:0] out_waddr_q, out_waddr_d;
    logic [XLEN-1:0]   out_wdata_q, out_wdata_d;
    logic              out_wen_q, out_wen_d;

    logic [REG_AW-1:0] skid_waddr_q, skid_waddr_d;
    logic [XLEN-1:0]   skid_wdata_q, skid_wdata_d;
    logic              skid_wen_q, skid_wen_d;

    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   sel_data;
    logic              accept;
    logic              xfer;

    load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .mem_rdata (mem_rdata),
        .funct3    (funct3),
        .addr_low  (addr_low),
        .ext_data  (load_data)
    );

    always_comb begin
        sel_data = alu_result;
        case (wb_sel)
            WB_SEL_ALU: sel_data = alu_result;
            WB_SEL_MEM: sel_data = load_data;
            WB_SEL_PC4: sel_data = pc + XLEN'(4);
            WB_SEL_IMM: sel_data = immediate;
            default:    sel_data = alu_result;
        endcase
    end

    assign accept    = in_valid & in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign xfer      = out_valid & rf_ready;

    always_comb begin
        state_d      = state_q;
        out_waddr_d  = out_waddr_q;
        out_wdata_d  = out_wdata_q;
        out_wen_d    = out_wen_q;
        skid_waddr_d = skid_waddr_q;
        skid_wdata_d = skid_wdata_q;
        skid_wen_d   = skid_wen_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d     = ST_ONE;
                    out_waddr_d = rd_addr;
                    out_wdata_d = sel_data;
                    out_wen_d   = rd_wen;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    out_waddr_d = rd_addr;
                    out_wdata_d = sel_data;
                    out_wen_d   = rd_wen;
                end else if (accept) begin
                    state_d      = ST_TWO;
                    skid_waddr_d = rd_addr;
                    skid_wdata_d = sel_data;
                    skid_wen_d   = rd_wen;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (xfer) begin
                    state_d     = ST_ONE;
                    out_waddr_d = skid_waddr_q;
                    out_wdata_d = skid_wdata_q;
                    out_wen_d   = skid_wen_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Registered ready: derived from next state, so no rf_ready->in_ready path.
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            out_waddr_q  <= '0;
            out_wdata_q  <= '0;
            out_wen_q    <= 1'b0;
            skid_waddr_q <= '0;
            skid_wdata_q <= '0;
            skid_wen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_waddr_q  <= out_waddr_d;
            out_wdata_q  <= out_wdata_d;
            out_wen_q    <= out_wen_d;
            skid_waddr_q <= skid_waddr_d;
            skid_wdata_q <= skid_wdata_d;
            skid_wen_q   <= skid_wen_d;
        end
    end

    assign in_ready = in_ready_q;
    assign rf_waddr = out_waddr_q;
    assign rf_wdata = out_wdata_q;
    // Writes to x0 still retire through the queue but never reach the file.
    assign rf_we    = out_valid & out_wen_q & (out_waddr_q != '0);

`ifdef WB_RETIRE_COUNT_EN
    logic [XLEN-1:0] retire_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_q <= '0;
        end else if (xfer) begin
            retire_q <= retire_q + XLEN'(1);
        end
    end

    assign retire_count = retire_q;
`else
    // No retire counter in this build.
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed, table-driven bench for alu_writeback_stage plus hand-written
// backpressure and mid-operation reset sequences.
module tb_alu_writeback_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        wb_sel;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   mem_rdata;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   immediate;
    logic [2:0]        funct3;
    logic [1:0]        addr_low;
    logic [REG_AW-1:0] rd_addr;
    logic              rd_wen;
    logic              rf_ready;
    logic              out_valid;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
`ifdef WB_RETIRE_COUNT_EN
    logic [XLEN-1:0]   retire_count;
`endif

    alu_writeback_stage #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wb_sel     (wb_sel),
        .alu_result (alu_result),
        .mem_rdata  (mem_rdata),
        .pc         (pc),
        .immediate  (immediate),
        .funct3     (funct3),
        .addr_low   (addr_low),
        .rd_addr    (rd_addr),
        .rd_wen     (rd_wen),
        .rf_ready   (rf_ready),
        .out_valid  (out_valid),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
`ifdef WB_RETIRE_COUNT_EN
        ,
        .retire_count (retire_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pcv;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [1:0]  al;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] exp_data;
        logic        exp_we;
    } vec_t;

    vec_t vecs[14];

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfers  = 0;

    logic [4:0]  log_addr[$];
    logic [31:0] log_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Records the write presented at the coming edge, then advances one cycle.
    task automatic step();
        if (rst_n && out_valid && rf_ready) begin
            n_xfers++;
            if (rf_we) begin
                log_addr.push_back(rf_waddr);
                log_data.push_back(rf_wdata);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pcv, input logic [31:0] imm, input logic [2:0] f3,
                         input logic [1:0] al, input logic [4:0] rd, input logic wen);
        wb_sel     = sel;
        alu_result = alu;
        mem_rdata  = mem;
        pc         = pcv;
        immediate  = imm;
        funct3     = f3;
        addr_low   = al;
        rd_addr    = rd;
        rd_wen     = wen;
    endtask

    initial begin
        vecs[0]  = '{2'b00, 32'hAAAAAAAA, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 5'd5,  1'b1, 32'hAAAAAAAA, 1'b1};
        vecs[1]  = '{2'b01, 32'h0, 32'h555580F0, 32'h0, 32'h0, 3'b000, 2'd0, 5'd6,  1'b1, 32'hFFFFFFF0, 1'b1};
        vecs[2]  = '{2'b01, 32'h0, 32'h555580F0, 32'h0, 32'h0, 3'b100, 2'd1, 5'd7,  1'b1, 32'h00000080, 1'b1};
        vecs[3]  = '{2'b01, 32'h0, 32'h555580F0, 32'h0, 32'h0, 3'b001, 2'd2, 5'd8,  1'b1, 32'h00005555, 1'b1};
        vecs[4]  = '{2'b01, 32'h0, 32'h555580F0, 32'h0, 32'h0, 3'b101, 2'd0, 5'd9,  1'b1, 32'h000080F0, 1'b1};
        vecs[5]  = '{2'b01, 32'h0, 32'h555580F0, 32'h0, 32'h0, 3'b010, 2'd0, 5'd10, 1'b1, 32'h555580F0, 1'b1};
        vecs[6]  = '{2'b01, 32'h0, 32'h555580F0, 32'h0, 32'h0, 3'b001, 2'd3, 5'd11, 1'b1, 32'h00005555, 1'b1};
        vecs[7]  = '{2'b01, 32'h0, 32'h555580F0, 32'h0, 32'h0, 3'b000, 2'd3, 5'd12, 1'b1, 32'h00000055, 1'b1};
        vecs[8]  = '{2'b01, 32'h0, 32'h555580F0, 32'h0, 32'h0, 3'b011, 2'd1, 5'd13, 1'b1, 32'h555580F0, 1'b1};
        vecs[9]  = '{2'b10, 32'h0, 32'h0, 32'h00400000, 32'h0, 3'b000, 2'd0, 5'd14, 1'b1, 32'h00400004, 1'b1};
        vecs[10] = '{2'b11, 32'h0, 32'h0, 32'h0, 32'h00001234, 3'b000, 2'd0, 5'd15, 1'b1, 32'h00001234, 1'b1};
        vecs[11] = '{2'b10, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0, 3'b000, 2'd0, 5'd16, 1'b1, 32'h00000000, 1'b1};
        vecs[12] = '{2'b00, 32'h12345678, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 5'd0,  1'b1, 32'h12345678, 1'b0};
        vecs[13] = '{2'b00, 32'h0BADF00D, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 5'd17, 1'b0, 32'h0BADF00D, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        rf_ready = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 5'd0, 1'b0);
        step();
        step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_rf_we",     {31'b0, rf_we},     32'd0);
        check("rst_waddr",     {27'b0, rf_waddr},  32'd0);
        check("rst_wdata",     rf_wdata,           32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Single-entry vectors: one accept, check, then drain.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].sel, vecs[i].alu, vecs[i].mem, vecs[i].pcv, vecs[i].imm,
                  vecs[i].f3, vecs[i].al, vecs[i].rd, vecs[i].wen);
            in_valid = 1'b1;
            rf_ready = 1'b1;
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("v%0d_wdata", i),     rf_wdata,           vecs[i].exp_data);
            check($sformatf("v%0d_waddr", i),     {27'b0, rf_waddr},  {27'b0, vecs[i].rd});
            check($sformatf("v%0d_rf_we", i),     {31'b0, rf_we},     {31'b0, vecs[i].exp_we});
            step();
            check($sformatf("v%0d_drained", i),   {31'b0, out_valid}, 32'd0);
        end

        // Backpressure: A held, B to skid, C held upstream, then in-order drain.
        log_addr.delete();
        log_data.delete();
        rf_ready = 1'b0;
        drive(2'b00, 32'hA0A0A0A0, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 5'd1, 1'b1);
        in_valid = 1'b1;
        step();
        check("bp_a_ready", {31'b0, in_ready}, 32'd1);
        drive(2'b00, 32'hB0B0B0B0, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 5'd2, 1'b1);
        step();
        check("bp_two_ready", {31'b0, in_ready}, 32'd0);
        check("bp_hold_a",    rf_wdata,          32'hA0A0A0A0);
        drive(2'b00, 32'hC0C0C0C0, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 5'd3, 1'b1);
        step();
        step();
        check("bp_still_a",     rf_wdata,          32'hA0A0A0A0);
        check("bp_still_a_we",  {31'b0, rf_we},    32'd1);
        check("bp_c_blocked",   {31'b0, in_ready}, 32'd0);
        rf_ready = 1'b1;
        step();
        check("bp_ready_back",  {31'b0, in_ready}, 32'd1);
        check("bp_out_b",       rf_wdata,          32'hB0B0B0B0);
        step();
        in_valid = 1'b0;
        check("bp_out_c",       rf_wdata,          32'hC0C0C0C0);
        step();
        check("bp_empty",       {31'b0, out_valid}, 32'd0);
        check("bp_write_count", log_data.size(),    32'd3);
        if (log_data.size() == 3) begin
            check("bp_w0", log_data[0], 32'hA0A0A0A0);
            check("bp_w1", log_data[1], 32'hB0B0B0B0);
            check("bp_w2", log_data[2], 32'hC0C0C0C0);
            check("bp_a2", {27'b0, log_addr[2]}, 32'd3);
        end

        // Reset while in TWO: pending entries discarded, in_valid ignored.
        log_data.delete();
        log_addr.delete();
        rf_ready = 1'b0;
        in_valid = 1'b1;
        drive(2'b00, 32'h11111111, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 5'd4, 1'b1);
        step();
        step();
        check("mr_in_two", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        step();
        check("mr_out_valid", {31'b0, out_valid}, 32'd0);
        check("mr_rf_we",     {31'b0, rf_we},     32'd0);
        check("mr_wdata",     rf_wdata,           32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        rf_ready = 1'b1;
        step();
        check("mr_in_ready",  {31'b0, in_ready},  32'd1);
        check("mr_idle",      {31'b0, out_valid}, 32'd0);
        check("mr_no_write",  log_data.size(),    32'd0);

`ifdef WB_RETIRE_COUNT_EN
        // Counter restarted at the mid-operation reset; no transfers since.
        check("retire_after_reset", retire_count, 32'd0);
        drive(2'b00, 32'h5, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 5'd0, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("retire_x0", retire_count, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
Writeback stage at the result end of the ALU datapath. It is the counterpart of the operand-select path: it receives the ALU result, load data, PC and immediate, and selects the register write-back value. Load data is sign- or zero-extended. The stage presents one register-file write per instruction through a valid/ready handshake, with a 2-entry skid buffer so the upstream ready signal is registered.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept; registered output
wb_sel  in  2  result source: 00 ALU, 01 MEM, 10 PC+4, 11 IMM (LUI)
alu_result  in  XLEN  ALU output
mem_rdata  in  XLEN  raw aligned data word from memory
pc  in  XLEN  instruction PC
immediate  in  XLEN  decoded immediate
funct3  in  3  load width/sign selector
addr_low  in  2  byte offset of the load address
rd_addr  in  REG_AW  destination register
rd_wen  in  1  instruction writes rd
rf_ready  in  1  register-file port accepts this cycle
out_valid  out  1  write entry presented
rf_we  out  1  out_valid & entry wen & (rf_waddr != 0)
rf_waddr  out  REG_AW  write address
rf_wdata  out  XLEN  write data

Behaviour:
- Reset, synchronous on rst_n=0 at a clk edge:
  - out_valid=0, rf_we=0, rf_waddr=0, rf_wdata=0.
  - Skid buffer emptied; in_ready=1 in the cycle after reset.
- Accept = in_valid & in_ready. Transfer = out_valid & rf_ready.
- Data select is combinational on the input side. The result is registered, so latency is 1 cycle from accept to out_valid.
- PC+4 is computed modulo 2^XLEN: pc=0xFFFFFFFC gives 0x00000000.
- Load extension (wb_sel=01):
  - funct3 000 LB: sign-extend byte mem_rdata[8*addr_low +: 8].
  - funct3 100 LBU: zero-extend the same byte.
  - funct3 001 LH / 101 LHU: halfword selected by addr_low[1]; addr_low[0] ignored; sign-/zero-extended.
  - funct3 010 LW, and any other code: full word.
- FSM states:
  - EMPTY: output register empty.
    - Accept -> ONE (load output register).
  - ONE: output register valid.
    - Accept & transfer -> ONE (output register reloaded).
    - Accept & !transfer -> TWO (new entry goes to skid).
    - !accept & transfer -> EMPTY.
  - TWO: output register and skid both valid; in_ready=0.
    - Transfer -> ONE (skid moves to output register).
    - Otherwise hold.
- in_ready is a register:
  - Goes low on the edge entering TWO.
  - Goes high on the edge leaving TWO.
  - No combinational path from rf_ready to in_ready.
- Ordering: strictly in order; no entry is dropped or duplicated.
- rd_addr=0 or rd_wen=0:
  - Entry still flows, occupies a slot and completes a transfer.
  - rf_we=0 for that entry.
- Output stability: while out_valid=1 and rf_ready=0, rf_waddr, rf_wdata and rf_we are held stable.
- Reset mid-operation: pending entries are discarded with no write. in_valid during the reset cycle is ignored.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- When defined: adds output port retire_count, XLEN bits.
  - Reset value 0.
  - Increments by 1 on each transfer, including rd=x0 and no-write entries.
  - Wraps 0xFFFFFFFF -> 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package wb_pkg holds:
  - WB_SEL_ALU, WB_SEL_MEM, WB_SEL_PC4, WB_SEL_IMM.
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - FSM state encodings.
- One combinational sub-module, load_extend (mem_rdata, funct3, addr_low -> extended data), instantiated in the select path.

Test Plan:
1. Reset, then a single ALU entry:
   - Stimulus: wb_sel=00, alu_result=0xAAAAAAAA, rd=5, rf_ready=1.
   - Required: next cycle out_valid=1, rf_we=1, rf_waddr=5, rf_wdata=0xAAAAAAAA.
   - Then out_valid=0.
2. Loads with mem_rdata=0x5555_80F0:
   - LB, addr_low=0 -> 0xFFFFFFF0.
   - LBU, addr_low=1 -> 0x00000080.
   - LH, addr_low=2 -> 0x00005555.
   - LHU, addr_low=0 -> 0x000080F0.
3. PC+4 and LUI:
   - pc=0x00400000, wb_sel=10 -> 0x00400004.
   - immediate=0x00001234, wb_sel=11 -> 0x00001234.
   - pc=0xFFFFFFFC, wb_sel=10 -> 0x00000000.
4. Backpressure:
   - Stimulus: rf_ready=0 while 3 back-to-back entries A, B, C are offered.
   - Required: A held on the outputs, B goes to skid, in_ready=0, C is held upstream.
   - On rf_ready=1: writes occur in order A, B, C with no loss; in_ready returns to 1.
5. Write to x0:
   - Stimulus: rd=0, rd_wen=1.
   - Required: out_valid=1, rf_we=0; with WB_RETIRE_COUNT_EN the counter still increments.
6. Reset mid-operation:
   - Stimulus: assert rst_n=0 while in state TWO.
   - Required: next cycle out_valid=0, no rf_we pulse; in_ready=1 after release.
